regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised 2-read/1-write register file for the LS1u datapath, successor to the fixed 32x64 file.
//  Adds configurable width/depth, optional hardwired-zero entry 0, write-to-read bypass, selectable compare modes
//  and a hardware clear sequencer. The sequencer zeroes the distributed RAM after reset or on request, since async reset cannot clear DRAM.
// PARAMETERS
//  DW      64  data width (bits)
//  AW       5  address width; DEPTH = 2**AW entries
//  ZERO_R0  1  1: entry 0 reads as 0, writes to it are discarded
//  BYPASS   1  1: read port returns di when we && addrw==addr (same-cycle write-through)
// PORTS
//  clk       in   1   clock, all state on rising edge
//  rst       in   1   asynchronous reset, active-high
//  addra     in   AW  read address port A
//  addrb     in   AW  read address port B
//  addrw     in   AW  write address
//  we        in   1   write enable
//  di        in   DW  write data
//  clear_req in   1   start a clear sweep (pulse, sampled when idle)
//  cmp_mode  in   2   compare select for j
//  doa       out  DW  read data A (combinational)
//  dob       out  DW  read data B (combinational)
//  j         out  1   compare result of doa vs dob (combinational)
//  busy      out  1   clear sweep in progress
//  wr_drop   out  1   registered 1-cycle pulse: a write was discarded
// BEHAVIOUR
//  Storage: DEPTH x DW regs, no reset on array (dram style). Reads are async and need 0 wait states.
//  Reset values: busy=1, wr_drop=0, state=CLEAR, clr_ptr=0. doa/dob/j are forced to 0 while busy.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle writes 0 to regmem[clr_ptr] and increments clr_ptr.
//    When clr_ptr==DEPTH-1, the next state is IDLE and busy falls.
//    busy is high for exactly DEPTH cycles after rst deassert.
//   IDLE: if clear_req, next state is CLEAR with clr_ptr=0 and busy=1 next cycle. Otherwise normal writes occur.
//  Write: in IDLE with we && !clear_req, regmem[addrw]<=di at the clock edge.
//   The write is skipped when ZERO_R0 && addrw==0.
//  wr_drop: asserted the cycle after we=1 is ignored, for any of these reasons:
//   - state CLEAR;
//   - clear_req in the same cycle (clear wins);
//   - a write to entry 0 with ZERO_R0=1.
//  Read mux per port, in priority order:
//   1. busy          -> 0
//   2. ZERO_R0 && addr==0 -> 0
//   3. BYPASS && IDLE && we && !clear_req && addrw==addr -> di
//   4. otherwise     -> regmem[addr]
//  Compare j (on final doa/dob):
//   00 unsigned doa>=dob
//   01 signed   doa>=dob
//   10 doa==dob
//   11 doa!=dob
//  While busy, j=0 regardless of mode.
//  Reset mid-sweep: async reset restarts the sweep at clr_ptr=0. clear_req while busy is ignored (no restart).
//  clr_ptr wraps naturally at AW bits; no other counters.
// TESTING
//  1 rst pulse -> busy=1 for exactly 32 cycles (AW=5), doa=dob=0; afterwards all 32 entries read 0.
//  2 IDLE, we=1 addrw=5 di=64'h1234, addra=5 -> doa=64'h1234 the same cycle (BYPASS=1).
//    Next cycle with we=0 -> doa=64'h1234 from storage.
//  3 we=1 addrw=0 di=64'hFFFF -> wr_drop=1 next cycle; addra=0 reads 0.
//  4 r1=64'hFFFF_FFFF_FFFF_FFFF, r2=1, addra=1 addrb=2:
//    cmp_mode 00 -> j=1; 01 -> j=0; 10 -> j=0; 11 -> j=1.
//  5 clear_req=1 together with we=1 addrw=7 -> write dropped, wr_drop=1, busy=1 for 32 cycles, r7 reads 0 afterwards.
//  6 Assert rst at sweep cycle 10 -> busy stays 1 and sweep completes 32 cycles after rst deassert.
//    we during the sweep -> wr_drop pulses, no data stored.

Source files
------------

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - port bundle for the 2-read/1-write register file
// Master drives addresses, write data and control; slave returns read data and status.
interface regfile_mp_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic [AW-1:0] addrw;
    logic          we;
    logic [DW-1:0] di;
    logic          clear_req;
    logic [1:0]    cmp_mode;
    logic [DW-1:0] doa;
    logic [DW-1:0] dob;
    logic          j;
    logic          busy;
    logic          wr_drop;

    modport master (
        output addra, addrb, addrw, we, di, clear_req, cmp_mode,
        input  doa, dob, j, busy, wr_drop
    );

    modport slave (
        input  addra, addrb, addrw, we, di, clear_req, cmp_mode,
        output doa, dob, j, busy, wr_drop
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised 2R/1W register file with bypass, compare and clear sweep
// The array has no reset, so a sweep zeroes it one entry per cycle after reset or on request.
module regfile_mp #(
    parameter int DW      = 64,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] clr_ptr_nx;
    logic          wr_drop_q;
    logic          wr_drop_nx;

    logic [DW-1:0] regmem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;

    logic          busy;
    logic          zero_hit;
    logic          idle_write;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          j_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state     <= state_nx;
            clr_ptr   <= clr_ptr_nx;
            wr_drop_q <= wr_drop_nx;
        end
    end

    assign zero_hit = (ZERO_R0 != 0) && (bus.addrw == '0);

    always_comb begin
        state_nx   = state;
        clr_ptr_nx = clr_ptr;
        wr_drop_nx = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = bus.addrw;
        mem_din    = bus.di;
        case (state)
            CLEAR: begin
                // the sweep owns the write port; any user write this cycle is lost
                mem_we     = 1'b1;
                mem_addr   = clr_ptr;
                mem_din    = '0;
                clr_ptr_nx = clr_ptr + AW'(1);
                wr_drop_nx = bus.we;
                if (clr_ptr == '1) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (bus.clear_req) begin
                    state_nx   = CLEAR;
                    clr_ptr_nx = '0;
                    wr_drop_nx = bus.we;
                end else if (bus.we) begin
                    if (zero_hit) begin
                        wr_drop_nx = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regmem[mem_addr] <= mem_din;
        end
    end

    assign busy       = (state == CLEAR);
    assign idle_write = (state == IDLE) && bus.we && !bus.clear_req;

    function automatic logic [DW-1:0] read_port(
        input logic [AW-1:0] addr,
        input logic          busy_i,
        input logic          wr_i,
        input logic [AW-1:0] waddr,
        input logic [DW-1:0] wdata,
        input logic [DW-1:0] stored
    );
        logic [DW-1:0] r;
        if (busy_i) begin
            r = '0;
        end else if ((ZERO_R0 != 0) && (addr == '0)) begin
            r = '0;
        end else if ((BYPASS != 0) && wr_i && (waddr == addr)) begin
            r = wdata;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    assign rd_a = read_port(bus.addra, busy, idle_write, bus.addrw, bus.di, regmem[bus.addra]);
    assign rd_b = read_port(bus.addrb, busy, idle_write, bus.addrw, bus.di, regmem[bus.addrb]);

    always_comb begin
        j_raw = 1'b0;
        case (bus.cmp_mode)
            2'b00:   j_raw = (rd_a >= rd_b);
            2'b01:   j_raw = ($signed(rd_a) >= $signed(rd_b));
            2'b10:   j_raw = (rd_a == rd_b);
            default: j_raw = (rd_a != rd_b);
        endcase
    end

    assign bus.doa     = rd_a;
    assign bus.dob     = rd_b;
    assign bus.j       = j_raw && !busy;
    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop_q;
endmodule
